// File: rtl/reaction_ctrl.sv
// Reaction-timer round sequencer: LED countdown, LFSR enable, delay start, reaction count.
// Optional false-start detection (FALSE state) is built when FALSE_START_EN is defined.
module reaction_ctrl #(
    parameter int N_LED       = 10,
    parameter int LIGHT_TICKS = 500,
    parameter int CNT_W       = 14,
    parameter int MAX_COUNT   = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             trigger,
    input  logic             time_out,
    input  logic             key,
    output logic [N_LED-1:0] ledr,
    output logic             en_lfsr,
    output logic             start_delay,
    output logic [CNT_W-1:0] react_ms,
    output logic             react_valid,
    output logic             false_start,
    output logic             busy
);

    localparam int TC_W  = (LIGHT_TICKS > 1) ? $clog2(LIGHT_TICKS) : 1;
    localparam int IDX_W = (N_LED > 1) ? $clog2(N_LED) : 1;

    localparam logic [TC_W-1:0]  TC_LAST   = TC_W'(LIGHT_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_START = IDX_W'(N_LED - 2);
    localparam logic [N_LED-1:0] LED_TOP   = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [N_LED-1:0] LED_ONE   = N_LED'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIGHT,
        S_ARM,
        S_WAIT,
        S_TIMING,
        S_DONE
`ifdef FALSE_START_EN
        ,
        S_FALSE
`endif
    } state_t;

    state_t state, state_n;

    logic trig_q0, trig_q1;
    logic key_s1, key_s2, key_q;
    logic trig_rise, key_rise;

    logic [TC_W-1:0]  tcnt, tcnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] rcnt, rcnt_n;

    logic [N_LED-1:0] ledr_n;
    logic             en_lfsr_n;
    logic             start_delay_n;
    logic [CNT_W-1:0] react_ms_n;
    logic             react_valid_n;
    logic             busy_n;

    assign trig_rise = trig_q0 & ~trig_q1;
    assign key_rise  = key_s2 & ~key_q;

`ifdef FALSE_START_EN
    logic false_n;
`endif

    // Trigger edge detect and key two-flop synchronizer with edge register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q0 <= 1'b0;
            trig_q1 <= 1'b0;
            key_s1  <= 1'b0;
            key_s2  <= 1'b0;
            key_q   <= 1'b0;
        end else begin
            trig_q0 <= trigger;
            trig_q1 <= trig_q0;
            key_s1  <= key;
            key_s2  <= key_s1;
            key_q   <= key_s2;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            idx         <= '0;
            rcnt        <= '0;
            ledr        <= '0;
            en_lfsr     <= 1'b0;
            start_delay <= 1'b0;
            react_ms    <= '0;
            react_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            tcnt        <= tcnt_n;
            idx         <= idx_n;
            rcnt        <= rcnt_n;
            ledr        <= ledr_n;
            en_lfsr     <= en_lfsr_n;
            start_delay <= start_delay_n;
            react_ms    <= react_ms_n;
            react_valid <= react_valid_n;
            busy        <= busy_n;
        end
    end

`ifdef FALSE_START_EN
    // False-start flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) false_start <= 1'b0;
        else        false_start <= false_n;
    end
`else
    assign false_start = 1'b0;
`endif

    // Next-state and next-output logic for one round
    always_comb begin
        state_n       = state;
        tcnt_n        = tcnt;
        idx_n         = idx;
        rcnt_n        = rcnt;
        ledr_n        = ledr;
        react_ms_n    = react_ms;
        react_valid_n = 1'b0;
`ifdef FALSE_START_EN
        false_n       = false_start;
`endif

        unique case (state)
            S_IDLE, S_DONE: begin
                if (trig_rise) begin
                    state_n = S_LIGHT;
                    ledr_n  = LED_TOP;
                    tcnt_n  = '0;
                    idx_n   = IDX_START;
                end
            end
`ifdef FALSE_START_EN
            S_FALSE: begin
                if (trig_rise) begin
                    state_n = S_LIGHT;
                    ledr_n  = LED_TOP;
                    tcnt_n  = '0;
                    idx_n   = IDX_START;
                    false_n = 1'b0;
                end
            end
`endif
            S_LIGHT: begin
`ifdef FALSE_START_EN
                if (key_rise) begin
                    state_n = S_FALSE;
                    ledr_n  = '0;
                    false_n = 1'b1;
                end else
`endif
                if (tick) begin
                    if (tcnt == TC_LAST) begin
                        ledr_n = ledr | (LED_ONE << idx);
                        tcnt_n = '0;
                        idx_n  = idx - IDX_W'(1);
                        if (idx == '0) state_n = S_ARM;
                    end else begin
                        tcnt_n = tcnt + TC_W'(1);
                    end
                end
            end
            S_ARM: begin
                state_n = S_WAIT;
`ifdef FALSE_START_EN
                if (key_rise) begin
                    state_n = S_FALSE;
                    ledr_n  = '0;
                    false_n = 1'b1;
                end
`endif
            end
            S_WAIT: begin
`ifdef FALSE_START_EN
                if (key_rise) begin
                    state_n = S_FALSE;
                    ledr_n  = '0;
                    false_n = 1'b1;
                end else
`endif
                if (time_out) begin
                    state_n = S_TIMING;
                    ledr_n  = '0;
                    rcnt_n  = '0;
                end
            end
            S_TIMING: begin
                if (key_rise) begin
                    state_n       = S_DONE;
                    react_ms_n    = rcnt;
                    react_valid_n = 1'b1;
                end else if (tick && rcnt != CNT_MAX) begin
                    rcnt_n = rcnt + CNT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        en_lfsr_n     = (state_n == S_LIGHT);
        start_delay_n = (state == S_ARM);
        busy_n        = 1'b1;
        if (state_n == S_IDLE || state_n == S_DONE) busy_n = 1'b0;
`ifdef FALSE_START_EN
        if (state_n == S_FALSE) busy_n = 1'b0;
`endif
    end

endmodule
